// File: rtl/filled_triangle_rasterizer.sv
// Filled triangle rasterizer: scans the clamped bounding box of one triangle
// in raster order and emits every covered pixel, one candidate per clock.
// Coverage is the inclusive, winding-independent three-edge-function test.
module filled_triangle_rasterizer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] x1,
    input  logic signed [31:0] y1,
    input  logic signed [31:0] x2,
    input  logic signed [31:0] y2,
    input  logic signed [31:0] x3,
    input  logic signed [31:0] y3,
    output logic [9:0]         OX1,
    output logic [8:0]         OY1,
    output logic               pixel_valid,
    output logic               finish
);

    typedef enum logic [1:0] {LOAD, SETUP, SCAN, DONE} state_t;

    localparam logic [9:0] XLAST = 10'(H_RES - 1);
    localparam logic [9:0] YLAST = 10'(V_RES - 1);

    function automatic logic [9:0] clamp_x(input logic signed [31:0] v);
        if (v < 0)              return '0;
        else if (v > H_RES - 1) return XLAST;
        else                    return v[9:0];
    endfunction

    function automatic logic [9:0] clamp_y(input logic signed [31:0] v);
        if (v < 0)              return '0;
        else if (v > V_RES - 1) return YLAST;
        else                    return v[9:0];
    endfunction

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // (Bx-Ax)*(Py-Ay) - (By-Ay)*(Px-Ax); operands are 11-bit signed differences
    function automatic logic signed [23:0] edge_fn(input logic [9:0] ax, input logic [9:0] ay,
                                                   input logic [9:0] bx, input logic [9:0] by,
                                                   input logic [9:0] px, input logic [9:0] py);
        logic signed [23:0] dx_ab, dy_ab, dx_ap, dy_ap;
        dx_ab = $signed({14'b0, bx}) - $signed({14'b0, ax});
        dy_ab = $signed({14'b0, by}) - $signed({14'b0, ay});
        dx_ap = $signed({14'b0, px}) - $signed({14'b0, ax});
        dy_ap = $signed({14'b0, py}) - $signed({14'b0, ay});
        return dx_ab * dy_ap - dy_ab * dx_ap;
    endfunction

    state_t     state_q, state_d;
    logic [9:0] xa_q, ya_q, xb_q, yb_q, xc_q, yc_q;
    logic [9:0] xa_d, ya_d, xb_d, yb_d, xc_d, yc_d;
    logic [9:0] xmin_q, xmax_q, ymax_q, xmin_d, xmax_d, ymax_d;
    logic [9:0] px_q, py_q, px_d, py_d;
    logic [9:0] ox_q, ox_d;
    logic [8:0] oy_q, oy_d;
    logic       pv_q, pv_d, fin_q, fin_d;

    logic signed [23:0] e_ab, e_bc, e_ca;
    logic               covered;

    // Edge functions for the current scan candidate
    always_comb begin
        e_ab    = edge_fn(xa_q, ya_q, xb_q, yb_q, px_q, py_q);
        e_bc    = edge_fn(xb_q, yb_q, xc_q, yc_q, px_q, py_q);
        e_ca    = edge_fn(xc_q, yc_q, xa_q, ya_q, px_q, py_q);
        covered = (e_ab >= 0 && e_bc >= 0 && e_ca >= 0) ||
                  (e_ab <= 0 && e_bc <= 0 && e_ca <= 0);
    end

    // Next-state and datapath update for LOAD -> SETUP -> SCAN -> DONE
    always_comb begin
        state_d = state_q;
        xa_d = xa_q; ya_d = ya_q; xb_d = xb_q; yb_d = yb_q; xc_d = xc_q; yc_d = yc_q;
        xmin_d = xmin_q; xmax_d = xmax_q; ymax_d = ymax_q;
        px_d = px_q; py_d = py_q;
        ox_d = ox_q; oy_d = oy_q;
        pv_d = 1'b0;
        fin_d = fin_q;
        case (state_q)
            LOAD: begin
                xa_d = clamp_x(x1); ya_d = clamp_y(y1);
                xb_d = clamp_x(x2); yb_d = clamp_y(y2);
                xc_d = clamp_x(x3); yc_d = clamp_y(y3);
                state_d = SETUP;
            end
            SETUP: begin
                xmin_d  = min3(xa_q, xb_q, xc_q);
                xmax_d  = max3(xa_q, xb_q, xc_q);
                ymax_d  = max3(ya_q, yb_q, yc_q);
                px_d    = xmin_d;
                py_d    = min3(ya_q, yb_q, yc_q);
                state_d = SCAN;
            end
            SCAN: begin
                if (covered) begin
                    ox_d = px_q;
                    oy_d = py_q[8:0];
                    pv_d = 1'b1;
                end
                if (px_q == xmax_q) begin
                    if (py_q == ymax_q) begin
                        state_d = DONE;
                        fin_d   = 1'b1;
                    end else begin
                        px_d = xmin_q;
                        py_d = py_q + 10'd1;
                    end
                end else begin
                    px_d = px_q + 10'd1;
                end
            end
            default: begin
                fin_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset restarts rasterization from LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            xa_q <= '0; ya_q <= '0; xb_q <= '0; yb_q <= '0; xc_q <= '0; yc_q <= '0;
            xmin_q <= '0; xmax_q <= '0; ymax_q <= '0;
            px_q <= '0; py_q <= '0;
            ox_q <= '0; oy_q <= '0;
            pv_q <= 1'b0;
            fin_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xa_q <= xa_d; ya_q <= ya_d; xb_q <= xb_d; yb_q <= yb_d; xc_q <= xc_d; yc_q <= yc_d;
            xmin_q <= xmin_d; xmax_q <= xmax_d; ymax_q <= ymax_d;
            px_q <= px_d; py_q <= py_d;
            ox_q <= ox_d; oy_q <= oy_d;
            pv_q <= pv_d;
            fin_q <= fin_d;
        end
    end

    assign OX1         = ox_q;
    assign OY1         = oy_q;
    assign pixel_valid = pv_q;
    assign finish      = fin_q;

endmodule

// File: tb/tb_filled_triangle_rasterizer.sv
// Directed bench for filled_triangle_rasterizer: vector table of triangles
// with hand-computed pixel counts, checksums, endpoints and finish timing,
// plus a hand-written mid-scan reset sequence.
module tb_filled_triangle_rasterizer;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] x1, y1, x2, y2, x3, y3;
    logic [9:0]         OX1;
    logic [8:0]         OY1;
    logic               pixel_valid;
    logic               finish;

    int checks = 0;
    int errors = 0;

    filled_triangle_rasterizer #(.H_RES(640), .V_RES(480)) dut (
        .clk(clk), .reset(reset),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .OX1(OX1), .OY1(OY1), .pixel_valid(pixel_valid), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ax, ay, bx, by, cx, cy;
        int    window;    // observation cycles after reset release
        int    ylim;      // pixels with y above this are not counted/summed
        bit    full;      // run expected to finish inside the window
        int    cnt;
        int    fx, fy, lx, ly;
        longint sx, sy;
        int    n;         // bounding-box candidate count
        int    xlo, xhi, ylo, yhi;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int     cnt, nall, fin_cyc, bad, dup, fx, fy, lx, ly;
        longint sx, sy;
        bit     seen [int];
        int     key;
        reset = 1'b1;
        x1 = v.ax; y1 = v.ay; x2 = v.bx; y2 = v.by; x3 = v.cx; y3 = v.cy;
        @(negedge clk);
        check({v.name, "_rst_ox"}, OX1, 0);
        check({v.name, "_rst_oy"}, OY1, 0);
        check({v.name, "_rst_pv"}, pixel_valid, 0);
        check({v.name, "_rst_fin"}, finish, 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0; nall = 0; fin_cyc = -1; bad = 0; dup = 0;
        fx = -1; fy = -1; lx = -1; ly = -1; sx = 0; sy = 0;
        for (int c = 1; c <= v.window; c++) begin
            @(negedge clk);
            if (pixel_valid) begin
                if (nall == 0) begin fx = OX1; fy = OY1; end
                nall++;
                lx = OX1; ly = OY1;
                if (OX1 < v.xlo || OX1 > v.xhi || OY1 < v.ylo || OY1 > v.yhi) bad++;
                key = int'(OX1) * 1024 + int'(OY1);
                if (seen.exists(key)) dup++;
                seen[key] = 1'b1;
                if (int'(OY1) <= v.ylim) begin
                    cnt++;
                    sx += OX1;
                    sy += OY1;
                end
            end
            if (finish && fin_cyc < 0) begin
                fin_cyc = c;
                break;
            end
        end
        check({v.name, "_count"}, cnt, v.cnt);
        check({v.name, "_sumx"}, sx, v.sx);
        check({v.name, "_sumy"}, sy, v.sy);
        check({v.name, "_first_x"}, fx, v.fx);
        check({v.name, "_first_y"}, fy, v.fy);
        check({v.name, "_out_of_box"}, bad, 0);
        check({v.name, "_duplicates"}, dup, 0);
        if (v.full) begin
            checks++;
            if (fin_cyc < v.n + 1 || fin_cyc > v.n + 3) begin
                errors++;
                $display("FAIL %s_finish_cycle: got %0d expected %0d (+/-1)", v.name, fin_cyc, v.n + 2);
            end
            check({v.name, "_last_x"}, lx, v.lx);
            check({v.name, "_last_y"}, ly, v.ly);
            repeat (3) @(negedge clk);
            check({v.name, "_done_pv"}, pixel_valid, 0);
            check({v.name, "_done_fin"}, finish, 1);
            check({v.name, "_hold_x"}, OX1, v.lx);
            check({v.name, "_hold_y"}, OY1, v.ly);
        end else begin
            check({v.name, "_no_finish"}, finish, 0);
        end
    endtask

    initial begin
        int pulses, fin_cyc, px, py;
        reset = 1'b1;
        x1 = 0; y1 = 0; x2 = 0; y2 = 0; x3 = 0; y3 = 0;

        //          name         ax  ay  bx  by  cx  cy  win  ylim full cnt  fx fy lx ly  sx      sy    n    box
        vecs[0] = '{"right",     10, 10, 20, 10, 10, 20, 131, 479, 1,  66,  10,10,10,20, 880,    880,  121, 10,20,10,20};
        vecs[1] = '{"reverse",   10, 20, 20, 10, 10, 10, 131, 479, 1,  66,  10,10,10,20, 880,    880,  121, 10,20,10,20};
        vecs[2] = '{"point",     5,  5,  5,  5,  5,  5,  11,  479, 1,  1,   5, 5, 5, 5,  5,      5,    1,   5,5,5,5};
        vecs[3] = '{"offscreen", -50,-50,700,0,  0,  600,1930,2,   0,  1915,0, 0, 0, 0,  610249, 1912, 0,   0,639,0,479};
        vecs[4] = '{"collinear", 0,  0,  4,  4,  2,  2,  35,  479, 1,  5,   0, 0, 4, 4,  10,     10,   25,  0,4,0,4};

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Mid-scan reset: start the right triangle, abort, re-sample a point
        reset = 1'b1;
        x1 = 10; y1 = 10; x2 = 20; y2 = 10; x3 = 10; y3 = 20;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_pre_active", (OX1 >= 10) && (OY1 >= 10), 1);
        check("abort_pre_fin", finish, 0);
        #2 reset = 1'b1;
        #1;
        check("abort_ox", OX1, 0);
        check("abort_oy", OY1, 0);
        check("abort_pv", pixel_valid, 0);
        check("abort_fin", finish, 0);
        x1 = 5; y1 = 5; x2 = 5; y2 = 5; x3 = 5; y3 = 5;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0; fin_cyc = -1; px = -1; py = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (pixel_valid) begin pulses++; px = OX1; py = OY1; end
            if (finish && fin_cyc < 0) fin_cyc = c;
        end
        check("abort_pulses", pulses, 1);
        check("abort_px", px, 5);
        check("abort_py", py, 5);
        checks++;
        if (fin_cyc < 2 || fin_cyc > 4) begin
            errors++;
            $display("FAIL abort_finish_cycle: got %0d expected 3 (+/-1)", fin_cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
